// File: rtl/hilo_muldiv_unit_if.sv
// HI/LO unit bus: EX-side request, HILO read-back and HILO write port.
interface hilo_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  op_valid;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic [DATA_WIDTH-1:0] hi_read_data;
  logic [DATA_WIDTH-1:0] lo_read_data;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] hi_write_data;
  logic [DATA_WIDTH-1:0] lo_write_data;
  logic                  hilo_write_en;
  logic                  stall_req;
  logic                  div_zero;

  // EX pipeline / HILO stage side
  modport master (
    output flush, op_valid, op, operand_1, operand_2, hi_read_data, lo_read_data,
    input  result, hi_write_data, lo_write_data, hilo_write_en, stall_req, div_zero
  );

  // the HI/LO unit itself
  modport slave (
    input  flush, op_valid, op, operand_1, operand_2, hi_read_data, lo_read_data,
    output result, hi_write_data, lo_write_data, hilo_write_en, stall_req, div_zero
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: MFHI/MFLO/MTHI/MTLO single-cycle, MULT/MULTU via a
// fixed-latency multiply, DIV/DIVU via a restoring radix-2 divider.
// The pipeline is held with stall_req until a one-cycle DONE writes HI/LO.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_MFHI  = 4'd1;
  localparam logic [3:0] OP_MFLO  = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // per-op control latched at accept
  typedef struct packed {
    logic is_signed;  // MULT / DIV
    logic neg_q;      // quotient sign fixup
    logic neg_r;      // remainder takes dividend sign
    logic dz;         // divide by zero
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   ctl;

  logic [W-1:0]          a_q, b_q;        // multiply operands
  logic [W-1:0]          rem, quo, dvs;   // divider: partial remainder, dividend/quotient, divisor magnitude
  logic [W-1:0]          res_hi, res_lo;  // final HI/LO presented in DONE
  logic [MUL_STAGES:0]   vld_pipe;        // multiply latency tracker, bit k set in MUL cycle k
  logic [CW-1:0]         cnt;             // divide bit counter

  logic                  kill, take, op_signed, is_mul, is_div, div_by_zero;
  logic [W-1:0]          mag_a, mag_b;
  logic [2*W-1:0]        a_ext, b_ext, product;
  logic [W:0]            rem_s, diff;
  logic [W-1:0]          r_nxt, q_nxt, q_fix, r_fix;

  // decode of the op presented in IDLE
  always_comb begin
    kill        = bus.flush | rst;
    take        = (state == IDLE) && bus.op_valid && !kill;
    op_signed   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_mul      = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div      = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    div_by_zero = (bus.operand_2 == '0);
    mag_a       = (op_signed && bus.operand_1[W-1]) ? -bus.operand_1 : bus.operand_1;
    mag_b       = (op_signed && bus.operand_2[W-1]) ? -bus.operand_2 : bus.operand_2;
  end

  // full-width product: extend then multiply, low 2W bits are exact for both signednesses
  always_comb begin
    a_ext   = ctl.is_signed ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    b_ext   = ctl.is_signed ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    product = a_ext * b_ext;
  end

  // one restoring-divide step plus the sign fixup applied on the last step
  always_comb begin
    rem_s = {rem, quo[W-1]};
    diff  = rem_s - {1'b0, dvs};
    r_nxt = diff[W] ? rem_s[W-1:0] : diff[W-1:0];
    q_nxt = {quo[W-2:0], ~diff[W]};
    q_fix = ctl.neg_q ? -q_nxt : q_nxt;
    r_fix = ctl.neg_r ? -r_nxt : r_nxt;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (take && is_mul)      state_nxt = MUL;
            else if (take && is_div) state_nxt = div_by_zero ? DONE : DIV;
      MUL:  if (vld_pipe[MUL_STAGES])   state_nxt = DONE;
      DIV:  if (cnt == CW'(W - 1))      state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // outputs; stall stays up through a flush cycle mid-op and drops the next cycle
  always_comb begin
    bus.result        = '0;
    bus.hi_write_data = '0;
    bus.lo_write_data = '0;
    bus.hilo_write_en = 1'b0;
    bus.stall_req     = 1'b0;
    bus.div_zero      = 1'b0;
    unique case (state)
      IDLE: if (take) begin
        unique case (bus.op)
          OP_MFHI: bus.result = bus.hi_read_data;
          OP_MFLO: bus.result = bus.lo_read_data;
          OP_MTHI: begin
            bus.hilo_write_en = 1'b1;
            bus.hi_write_data = bus.operand_1;
            bus.lo_write_data = bus.lo_read_data;
          end
          OP_MTLO: begin
            bus.hilo_write_en = 1'b1;
            bus.hi_write_data = bus.hi_read_data;
            bus.lo_write_data = bus.operand_1;
          end
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: bus.stall_req = 1'b1;
          default: ;
        endcase
      end
      MUL, DIV: bus.stall_req = 1'b1;
      DONE: if (!kill) begin
        bus.hilo_write_en = 1'b1;
        bus.hi_write_data = res_hi;
        bus.lo_write_data = res_lo;
        bus.div_zero      = ctl.dz;
      end
      default: ;
    endcase
  end

  // datapath: latch at accept, run multiply latency / divide steps, capture results
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      vld_pipe <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: if (take && (is_mul || is_div)) begin
          a_q           <= bus.operand_1;
          b_q           <= bus.operand_2;
          ctl.is_signed <= op_signed;
          ctl.neg_q     <= op_signed && (bus.operand_1[W-1] ^ bus.operand_2[W-1]);
          ctl.neg_r     <= op_signed && bus.operand_1[W-1];
          ctl.dz        <= is_div && div_by_zero;
          vld_pipe      <= (MUL_STAGES + 1)'(2);
          cnt           <= '0;
          rem           <= '0;
          quo           <= mag_a;
          dvs           <= mag_b;
          if (is_div && div_by_zero) begin
            res_hi <= bus.operand_1;
            res_lo <= '1;
          end
        end
        MUL: begin
          vld_pipe <= {vld_pipe[MUL_STAGES-1:0], 1'b0};
          if (vld_pipe[MUL_STAGES]) {res_hi, res_lo} <= product;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          rem <= r_nxt;
          quo <= q_nxt;
          if (cnt == CW'(W - 1)) begin
            res_lo <= q_fix;
            res_hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: the driver pushes expected responses
// from an arithmetic reference model, a monitor pops them as the DUT writes
// HI/LO or returns an MFxx result.
module tb_hilo_muldiv_unit;
  localparam int DW = 32;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.DATA_WIDTH(DW)) bus ();

  hilo_muldiv_unit #(.DATA_WIDTH(DW), .MUL_STAGES(MS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_read;
    logic [3:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    bit          dz;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: plain 64-bit arithmetic on the architectural rules
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b, hrd, lrd);
    exp_t e;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    e = '{is_read: 1'b0, op: op, hi: '0, lo: '0, res: '0, dz: 1'b0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin e.is_read = 1'b1; e.res = hrd; end
      4'd2: begin e.is_read = 1'b1; e.res = lrd; end
      4'd3: begin e.hi = a;   e.lo = lrd; end
      4'd4: begin e.hi = hrd; e.lo = a;   end
      4'd5: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      4'd6: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      4'd7, 4'd8: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 4'd7) begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int exp_stalls(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd5 || op == 4'd6) return MS + 1;
    if (op == 4'd7 || op == 4'd8) return (b == 0) ? 1 : DW + 1;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // monitor: every DUT output event pops one expectation
  always @(negedge clk) begin
    bit mf, ok;
    exp_t e;
    mf = bus.op_valid && (bus.op == 4'd1 || bus.op == 4'd2) && !bus.flush && !rst;
    if (bus.hilo_write_en || bus.div_zero || mf) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output we=%0b dz=%0b hi=%h lo=%h res=%h (nothing expected)",
                  bus.hilo_write_en, bus.div_zero, bus.hi_write_data, bus.lo_write_data, bus.result);
      end else begin
        e = q.pop_front();
        if (e.is_read)
          ok = mf && !bus.hilo_write_en && (bus.result == e.res);
        else
          ok = bus.hilo_write_en && (bus.hi_write_data == e.hi) && (bus.lo_write_data == e.lo) &&
               (bus.div_zero == e.dz) && (bus.result == 0);
        if (!ok) begin
          miscompares++;
          $display("FAIL response op=%0d got we=%0b hi=%h lo=%h dz=%0b res=%h exp hi=%h lo=%h dz=%0b res=%h",
                   e.op, bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data, bus.div_zero,
                   bus.result, e.hi, e.lo, e.dz, e.res);
        end
      end
    end
  end

  // issue one op, count stall cycles until the pipeline may advance
  task automatic issue(input logic [3:0] op, input logic [31:0] a, b, hrd, lrd, input bit fl);
    int stalls = 0;
    int exp_st;
    bit done = 0;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = op; bus.operand_1 = a; bus.operand_2 = b;
    bus.hi_read_data = hrd; bus.lo_read_data = lrd; bus.flush = fl;
    exp_st = fl ? 0 : exp_stalls(op, b);
    if (!fl && op >= 4'd1 && op <= 4'd8) q.push_back(model(op, a, b, hrd, lrd));
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.stall_req) stalls++; else done = 1;
      if (!done) begin
        @(posedge clk); #1;
        bus.flush = 1'b0;
        // held instruction: operands and HI/LO read-back must be ignored now
        bus.operand_1 = $urandom; bus.operand_2 = $urandom;
        bus.hi_read_data = $urandom; bus.lo_read_data = $urandom;
      end
    end
    vectors++;
    if (!done || stalls != exp_st) begin
      miscompares++;
      $display("FAIL stall_cycles op=%0d a=%h b=%h got=%0d exp=%0d done=%0b", op, a, b, stalls, exp_st, done);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = 4'd0; bus.flush = 1'b0;
  endtask

  // start a DIV and kill it at cycle 10 with flush or rst, then MULT back-to-back
  task automatic abort_div(input bit use_rst);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 4'd7; bus.operand_1 = 32'hFFFF_FFF9; bus.operand_2 = 32'd2;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.stall_req !== 1'b1 || bus.hilo_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cycle rst=%0b got stall=%0b we=%0b exp stall=1 we=0", use_rst, bus.stall_req, bus.hilo_write_en);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op = 4'd0;
    @(negedge clk);
    vectors++;
    if (bus.stall_req !== 1'b0 || bus.hilo_write_en !== 1'b0 || bus.hi_write_data !== '0 ||
        bus.lo_write_data !== '0 || bus.div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort rst=%0b got stall=%0b we=%0b hi=%h lo=%h dz=%0b exp all 0",
               use_rst, bus.stall_req, bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data, bus.div_zero);
    end
    issue(4'd5, 32'd6, 32'hFFFF_FFFD, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op = 4'd0;
    bus.operand_1 = '0; bus.operand_2 = '0; bus.hi_read_data = '0; bus.lo_read_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.result !== '0 || bus.hi_write_data !== '0 || bus.lo_write_data !== '0 ||
        bus.hilo_write_en !== 1'b0 || bus.stall_req !== 1'b0 || bus.div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got res=%h hi=%h lo=%h we=%0b st=%0b dz=%0b exp all 0",
               bus.result, bus.hi_write_data, bus.lo_write_data, bus.hilo_write_en, bus.stall_req, bus.div_zero);
    end
    @(posedge clk); #1 rst = 1'b0;

    // directed corner cases
    issue(4'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0);
    issue(4'd7, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0);
    issue(4'd8, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    issue(4'd8, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(4'd7, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(4'd3, 32'h1234, 32'd0, 32'h77, 32'hAA, 1'b0);
    issue(4'd2, 32'd0, 32'd0, 32'h66, 32'h55, 1'b0);
    issue(4'd1, 32'd0, 32'd0, 32'h66, 32'h55, 1'b0);
    issue(4'd4, 32'hBEEF, 32'd0, 32'h99, 32'h11, 1'b0);
    issue(4'd3, 32'hDEAD, 32'd0, 32'h1, 32'h2, 1'b1);
    issue(4'd7, 32'd9, 32'd3, 32'h1, 32'h2, 1'b1);
    issue(4'd12, 32'd1, 32'd1, 32'h1, 32'h2, 1'b0);
    issue(4'd0, 32'd1, 32'd1, 32'h1, 32'h2, 1'b0);

    abort_div(1'b0);
    abort_div(1'b1);

    // randomized mix, occasional flush on the accept cycle
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = 4'($urandom_range(5, 8));
      issue(op, pick(), pick(), $urandom, $urandom, ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations got=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
